// File: rtl/frog_game_fsm.sv
// frog_game_fsm: per-frame collision/goal detection and game-state sequencing
// (IDLE/PLAY/HIT/WIN/OVER) with lives and level counters for the frog game.
// Optional feature macro: FROG_FLASH_EN -- when defined, the frog blinks while
// in HIT (flash toggles every 8 frame ticks, starting high); otherwise flash=0.
module frog_game_fsm #(
  parameter int PLAYER_W     = 32,
  parameter int PLAYER_H     = 32,
  parameter int CAR_W        = 64,
  parameter int CAR_H        = 32,
  parameter int LANE0_Y      = 128,
  parameter int LANE_PITCH   = 64,
  parameter int GOAL_Y       = 32,
  parameter int START_LIVES  = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int MAX_LEVEL    = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] car_x1,
  input  logic [9:0] car_x2,
  input  logic [9:0] car_x3,
  input  logic [9:0] car_x4,
  output logic       respawn,
  output logic       freeze,
  output logic [2:0] game_state,
  output logic [2:0] lives,
  output logic [2:0] level,
  output logic       hit_pulse,
  output logic       flash
);

  localparam int TW = $clog2(PAUSE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    lives_q, lives_d;
  logic [2:0]    level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          respawn_q, respawn_d;
  logic          hit_q, hit_d;
  logic          freeze_q, freeze_d;
  logic          collision;
  logic [9:0]    car_x [4];

  assign car_x[0] = car_x1;
  assign car_x[1] = car_x2;
  assign car_x[2] = car_x3;
  assign car_x[3] = car_x4;

  // Box overlap test; all sums widened to 11 bits so a car near x=1023 cannot wrap.
  always_comb begin
    logic [10:0] px, py, cx, ly;
    collision = 1'b0;
    px = {1'b0, player_x};
    py = {1'b0, player_y};
    for (int i = 0; i < 4; i++) begin
      cx = {1'b0, car_x[i]};
      ly = 11'(LANE0_Y + i * LANE_PITCH);
      if ((px < cx + 11'(CAR_W)) && (cx < px + 11'(PLAYER_W)) &&
          (py < ly + 11'(CAR_H)) && (ly < py + 11'(PLAYER_H)))
        collision = 1'b1;
    end
  end

  // Next-state, counter and pulse logic; frame_tick only matters in PLAY/HIT/WIN.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    timer_d   = timer_q;
    respawn_d = 1'b0;
    hit_d     = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d   = S_PLAY;
          respawn_d = 1'b1;
          lives_d   = 3'(START_LIVES);
          level_d   = 3'd0;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (collision) begin
            state_d = S_HIT;
            lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
            hit_d   = 1'b1;
            timer_d = TW'(PAUSE_FRAMES);
          end else if (player_y <= 10'(GOAL_Y)) begin
            state_d = S_WIN;
            level_d = (level_q >= 3'(MAX_LEVEL)) ? level_q : level_q + 3'd1;
            timer_d = TW'(PAUSE_FRAMES);
          end
        end
      end
      S_HIT, S_WIN: begin
        if (frame_tick) begin
          if (timer_q <= TW'(1)) begin
            timer_d = '0;
            if (state_q == S_HIT && lives_q == 3'd0) begin
              state_d = S_OVER;
            end else begin
              state_d   = S_PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    freeze_d = (state_d != S_PLAY);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      lives_q   <= 3'(START_LIVES);
      level_q   <= 3'd0;
      timer_q   <= '0;
      respawn_q <= 1'b0;
      hit_q     <= 1'b0;
      freeze_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
      respawn_q <= respawn_d;
      hit_q     <= hit_d;
      freeze_q  <= freeze_d;
    end
  end

`ifdef FROG_FLASH_EN
  logic       flash_q, flash_d;
  logic [2:0] fcnt_q, fcnt_d;

  // Blink control: high on HIT entry, toggles after every 8th tick spent in HIT.
  always_comb begin
    flash_d = 1'b0;
    fcnt_d  = 3'd0;
    if (state_d == S_HIT) begin
      if (state_q != S_HIT) begin
        flash_d = 1'b1;
      end else begin
        flash_d = flash_q;
        fcnt_d  = fcnt_q;
        if (frame_tick) begin
          fcnt_d = fcnt_q + 3'd1;
          if (fcnt_q == 3'd7) flash_d = ~flash_q;
        end
      end
    end
  end

  // Blink register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flash_q <= 1'b0;
      fcnt_q  <= 3'd0;
    end else begin
      flash_q <= flash_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

  assign respawn    = respawn_q;
  assign hit_pulse  = hit_q;
  assign freeze     = freeze_q;
  assign game_state = state_q;
  assign lives      = lives_q;
  assign level      = level_q;

endmodule

// File: tb/tb_frog_game_fsm.sv
// Testbench for frog_game_fsm: directed scenarios followed by randomized play,
// every cycle compared against a behavioural game model.
// Lane 0 is moved to y=16 so that a goal-line frog can also overlap a car.
module tb_frog_game_fsm;

  localparam int PW = 32, PH = 32, CW = 64, CH = 32;
  localparam int L0 = 16, PITCH = 64, GOAL = 32;
  localparam int LIVES0 = 3, PAUSE = 60, MAXLV = 7;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_HIT = 2, ST_WIN = 3, ST_OVER = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] player_x = '0, player_y = '0;
  logic [9:0] car_x1 = '0, car_x2 = '0, car_x3 = '0, car_x4 = '0;
  logic       respawn, freeze, hit_pulse, flash;
  logic [2:0] game_state, lives, level;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_state = ST_IDLE, m_lives = LIVES0, m_level = 0, m_timer = 0, m_hticks = 0;
  int m_resp = 0, m_hit = 0, m_freeze = 1;

  frog_game_fsm #(
    .PLAYER_W(PW), .PLAYER_H(PH), .CAR_W(CW), .CAR_H(CH),
    .LANE0_Y(L0), .LANE_PITCH(PITCH), .GOAL_Y(GOAL),
    .START_LIVES(LIVES0), .PAUSE_FRAMES(PAUSE), .MAX_LEVEL(MAXLV)
  ) u_dut (
    .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .start(start),
    .player_x(player_x), .player_y(player_y),
    .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
    .respawn(respawn), .freeze(freeze), .game_state(game_state),
    .lives(lives), .level(level), .hit_pulse(hit_pulse), .flash(flash)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit frog_hits_car();
    int cars [4];
    int px, py;
    cars[0] = int'(car_x1); cars[1] = int'(car_x2);
    cars[2] = int'(car_x3); cars[3] = int'(car_x4);
    px = int'(player_x);
    py = int'(player_y);
    for (int i = 0; i < 4; i++) begin
      if (px < cars[i] + CW && cars[i] < px + PW &&
          py < L0 + i * PITCH + CH && L0 + i * PITCH < py + PH)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(bit t, bit s, bit r);
    m_resp = 0;
    m_hit  = 0;
    if (r) begin
      m_state = ST_IDLE; m_lives = LIVES0; m_level = 0; m_timer = 0;
    end else if (m_state == ST_IDLE || m_state == ST_OVER) begin
      if (s) begin
        m_state = ST_PLAY; m_resp = 1; m_lives = LIVES0; m_level = 0;
      end
    end else if (m_state == ST_PLAY) begin
      if (t && frog_hits_car()) begin
        m_state = ST_HIT; m_hit = 1; m_timer = PAUSE; m_hticks = 0;
        if (m_lives > 0) m_lives = m_lives - 1;
      end else if (t && int'(player_y) <= GOAL) begin
        m_state = ST_WIN; m_timer = PAUSE;
        if (m_level < MAXLV) m_level = m_level + 1;
      end
    end else if (t) begin
      m_timer = m_timer - 1;
      m_hticks = m_hticks + 1;
      if (m_timer == 0) begin
        if (m_state == ST_HIT && m_lives == 0) m_state = ST_OVER;
        else begin m_state = ST_PLAY; m_resp = 1; end
      end
    end
    m_freeze = (m_state != ST_PLAY) ? 1 : 0;
  endtask

  task automatic step(bit t, bit s, bit r);
    int exp_flash;
    frame_tick = t; start = s; RST = r;
    @(posedge CLK);
    model_edge(t, s, r);
    #1;
`ifdef FROG_FLASH_EN
    exp_flash = (m_state == ST_HIT && ((m_hticks / 8) % 2) == 0) ? 1 : 0;
`else
    exp_flash = 0;
`endif
    chk("game_state", 32'(game_state), m_state);
    chk("lives", 32'(lives), m_lives);
    chk("level", 32'(level), m_level);
    chk("freeze", 32'(freeze), m_freeze);
    chk("respawn", 32'(respawn), m_resp);
    chk("hit_pulse", 32'(hit_pulse), m_hit);
    chk("flash", 32'(flash), exp_flash);
    frame_tick = 1'b0; start = 1'b0; RST = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    player_x = 10'd300; player_y = 10'd400;

    // Reset state
    step(1'b0, 1'b0, 1'b1);
    chk("rst_state", 32'(game_state), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_level", 32'(level), 0);
    chk("rst_freeze", 32'(freeze), 1);
    chk("rst_respawn", 32'(respawn), 0);

    // Start from IDLE
    step(1'b0, 1'b1, 1'b0);
    chk("start_state", 32'(game_state), 1);
    chk("start_respawn", 32'(respawn), 1);
    chk("start_freeze", 32'(freeze), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("respawn_1cyc", 32'(respawn), 0);

    // Collision in lane 1
    player_x = 10'd300; player_y = 10'd80; car_x2 = 10'd280;
    step(1'b1, 1'b0, 1'b0);
    chk("hit_state", 32'(game_state), 2);
    chk("hit_lives", 32'(lives), 2);
    chk("hit_pulse", 32'(hit_pulse), 1);
    player_y = 10'd400; car_x2 = 10'd0;
    ticks(59);
    chk("hit_hold", 32'(game_state), 2);
    ticks(1);
    chk("hit_resume", 32'(game_state), 1);
    chk("hit_respawn", 32'(respawn), 1);

    // Goal reached
    player_y = 10'd32; car_x1 = 10'd600;
    step(1'b1, 1'b0, 1'b0);
    chk("win_state", 32'(game_state), 3);
    chk("win_level", 32'(level), 1);
    ticks(60);
    chk("win_resume", 32'(game_state), 1);
    chk("win_respawn", 32'(respawn), 1);

    // Goal and collision in the same frame: collision wins
    player_y = 10'd16; car_x1 = 10'd290;
    step(1'b1, 1'b0, 1'b0);
    chk("prio_state", 32'(game_state), 2);
    chk("prio_level", 32'(level), 1);
    chk("prio_lives", 32'(lives), 1);
    player_y = 10'd400;
    ticks(60);

    // Last life lost -> OVER, then restart
    player_y = 10'd80; car_x2 = 10'd280;
    step(1'b1, 1'b0, 1'b0);
    chk("last_lives", 32'(lives), 0);
    player_y = 10'd400; car_x2 = 10'd0;
    ticks(60);
    chk("over_state", 32'(game_state), 4);
    chk("over_freeze", 32'(freeze), 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("restart_state", 32'(game_state), 1);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_level", 32'(level), 0);

    // Right screen edge: car at x=1000 must not wrap onto x=0
    car_x1 = 10'd600; player_x = 10'd0; player_y = 10'd208; car_x4 = 10'd1000;
    step(1'b1, 1'b0, 1'b0);
    chk("nowrap_state", 32'(game_state), 1);

    // Reset mid-WIN aborts to IDLE
    car_x4 = 10'd0; player_x = 10'd300; player_y = 10'd32;
    step(1'b1, 1'b0, 1'b0);
    chk("win2_state", 32'(game_state), 3);
    ticks(30);
    step(1'b0, 1'b0, 1'b1);
    chk("abort_state", 32'(game_state), 0);
    chk("abort_level", 32'(level), 0);

    // Randomized play
    for (int n = 0; n < 4000; n++) begin
      player_x = 10'($urandom_range(0, 1023));
      player_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40))
                                             : 10'($urandom_range(0, 400));
      car_x1 = 10'($urandom_range(0, 1023));
      car_x2 = 10'($urandom_range(0, 1023));
      car_x3 = 10'($urandom_range(0, 1023));
      car_x4 = 10'($urandom_range(0, 1023));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 799) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
